// File: rtl/y_div_pkg.sv
// Shared types and constants for the restoring divider.
package y_div_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned CNT_WIDTH = $clog2(DIV_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

endpackage

// File: rtl/y_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module y_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < divisor on entry, so the top trial bit is set exactly when the subtract borrows.
   assign shifted = {rem, bit_in};
   assign trial   = shifted - {1'b0, divisor};
   assign q_bit   = ~trial[WIDTH];
   assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/y_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// Optional signed mode is enabled by defining YDIV_SIGNED_EN.
module y_divider
   import y_div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef YDIV_SIGNED_EN
   input  logic             is_signed,
`endif
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   div_state_t       state;
   logic [WIDTH-1:0] rem_r, quo_r, dvsr_r;
   logic [CW-1:0]    cnt;
   logic             q_neg, r_neg;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] step_rem, quo_next;
   logic             step_bit;

`ifdef YDIV_SIGNED_EN
   assign a_neg = is_signed & dividend[WIDTH-1];
   assign b_neg = is_signed & divisor[WIDTH-1];
`else
   assign a_neg = 1'b0;
   assign b_neg = 1'b0;
`endif
   assign a_mag = a_neg ? -dividend : dividend;
   assign b_mag = b_neg ? -divisor : divisor;

   y_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem     (rem_r),
      .bit_in  (quo_r[WIDTH-1]),
      .divisor (dvsr_r),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   assign quo_next = {quo_r[WIDTH-2:0], step_bit};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
         rem_r     <= '0;
         quo_r     <= '0;
         dvsr_r    <= '0;
         cnt       <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (start) begin
                  if (divisor == '0) begin
                     // Division by zero skips iteration; remainder reports the raw dividend.
                     state     <= DONE;
                     done      <= 1'b1;
                     div_zero  <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend;
                  end else begin
                     state    <= RUN;
                     busy     <= 1'b1;
                     div_zero <= 1'b0;
                     quo_r    <= a_mag;
                     rem_r    <= '0;
                     dvsr_r   <= b_mag;
                     cnt      <= CW'(WIDTH);
                     q_neg    <= a_neg ^ b_neg;
                     r_neg    <= a_neg;
                  end
               end
            end
            RUN: begin
               rem_r <= step_rem;
               quo_r <= quo_next;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= q_neg ? -quo_next : quo_next;
                  remainder <= r_neg ? -step_rem : step_rem;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_y_divider.sv
// Self-checking bench for y_divider: arithmetic reference model plus directed vectors.
module tb_y_divider;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          sgn = 1'b0;
   logic [W-1:0]  quotient, remainder;
   logic          busy, done, div_zero;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   y_divider #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
`ifdef YDIV_SIGNED_EN
      .is_signed (sgn),
`endif
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference arithmetic straight from the operator definitions.
   function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, b, input logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return W'(sa / sb);
      end
      return a / b;
   endfunction

   function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, b, input logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return W'(sa % sb);
      end
      return a % b;
   endfunction

   // Timing model: an accepted request finishes W edges later; no acceptance while pending.
   bit           m_valid = 1'b0;
   bit           pending = 1'b0;
   int           cyc = 0, fin_cyc = 0;
   logic [W-1:0] m_q, m_r, p_q, p_r;
   logic         m_busy, m_done, m_dz;
   logic         s_eff;

`ifdef YDIV_SIGNED_EN
   assign s_eff = sgn;
`else
   assign s_eff = 1'b0;
`endif

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b1;
         pending <= 1'b0;
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_dz    <= 1'b0;
         m_q     <= '0;
         m_r     <= '0;
      end else if (m_valid) begin
         m_done <= 1'b0;
         if (pending && cyc == fin_cyc) begin
            m_done  <= 1'b1;
            m_busy  <= 1'b0;
            m_q     <= p_q;
            m_r     <= p_r;
            pending <= 1'b0;
         end else if (!pending && start) begin
            if (divisor == '0) begin
               m_done <= 1'b1;
               m_dz   <= 1'b1;
               m_q    <= '1;
               m_r    <= dividend;
            end else begin
               pending <= 1'b1;
               fin_cyc <= cyc + W;
               m_busy  <= 1'b1;
               m_dz    <= 1'b0;
               p_q     <= ref_q(dividend, divisor, s_eff);
               p_r     <= ref_r(dividend, divisor, s_eff);
            end
         end
         cyc <= cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_busy", {31'b0, busy}, {31'b0, m_busy});
         chk("m_done", {31'b0, done}, {31'b0, m_done});
         chk("m_div_zero", {31'b0, div_zero}, {31'b0, m_dz});
         chk("m_quotient", quotient, m_q);
         chk("m_remainder", remainder, m_r);
      end
   end

   task automatic launch(input logic [W-1:0] a, b, input logic s);
      @(negedge clk);
      #1;
      dividend = a;
      divisor  = b;
      sgn      = s;
      start    = 1'b1;
   endtask

   task automatic wait_done(input bit drop, output int lat, output int bc);
      bit seen;
      lat  = 0;
      bc   = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (busy) bc++;
         if (done) seen = 1'b1;
         if (drop && lat == 1) begin
            #1 start = 1'b0;
         end
      end
      chk("done_seen", {31'b0, seen}, 32'd1);
   endtask

   task automatic do_div(input logic [W-1:0] a, b, input logic s, input logic [W-1:0] eq, er,
                         input logic edz, input int elat, input int ebusy);
      int lat, bc;
      launch(a, b, s);
      wait_done(1'b1, lat, bc);
      chk("latency", lat, elat);
      chk("busy_cycles", bc, ebusy);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("div_zero", {31'b0, div_zero}, {31'b0, edz});
   endtask

   task automatic chk_all_zero();
      chk("z_quotient", quotient, '0);
      chk("z_remainder", remainder, '0);
      chk("z_busy", {31'b0, busy}, '0);
      chk("z_done", {31'b0, done}, '0);
      chk("z_div_zero", {31'b0, div_zero}, '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat, bc;
      bit  saw_done;

      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_all_zero();

      do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 32);
      do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 32);
      do_div(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33, 32);
      do_div(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 0);
      do_div(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 33, 32);

      // Start pulsed mid-run with other operands must be ignored.
      launch(32'd100, 32'd7, 1'b0);
      @(negedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      dividend = 32'd50;
      divisor  = 32'd3;
      start    = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      wait_done(1'b0, lat, bc);
      chk("midrun_lat", lat, 27);
      chk("midrun_q", quotient, 32'd14);
      chk("midrun_r", remainder, 32'd2);

      // Start held through DONE chains the next division with no idle gap.
      launch(32'd1000, 32'd10, 1'b0);
      wait_done(1'b0, lat, bc);
      chk("held1_lat", lat, 33);
      chk("held1_q", quotient, 32'd100);
      chk("held1_r", remainder, 32'd0);
      #1;
      dividend = 32'd77;
      divisor  = 32'd5;
      wait_done(1'b1, lat, bc);
      chk("held2_lat", lat, 33);
      chk("held2_busy", bc, 32);
      chk("held2_q", quotient, 32'd15);
      chk("held2_r", remainder, 32'd2);

      // Reset during RUN abandons the division.
      launch(32'd100, 32'd7, 1'b0);
      @(negedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk_all_zero();
      #1 rst = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("no_done_after_rst", {31'b0, saw_done}, '0);
      do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 32);

`ifdef YDIV_SIGNED_EN
      do_div(-32'sd7, 32'd2, 1'b1, -32'sd3, -32'sd1, 1'b0, 33, 32);
      do_div(32'd7, -32'sd2, 1'b1, -32'sd3, 32'd1, 1'b0, 33, 32);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 32);
      do_div(-32'sd5, 32'd0, 1'b1, 32'hFFFF_FFFF, -32'sd5, 1'b1, 1, 0);
      do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 32);
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
